vga_scene_seq: RTL and testbench

Parametrised scene sequencer for the VGA display path. It replaces the fixed three-state picture selector with N scenes and with debounced next and previous buttons. It also adds an optional timed auto-advance. It runs in the sys_clk domain and drives the index/one-hot select that the top-level pixel mux uses to choose between picture generators.

---
 rtl/vga_scene_seq.sv | 147 ++++++++++++++
 tb/tb_vga_scene_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scene_seq.sv
// rtl/vga_scene_seq.sv - N-scene selector with debounced next/prev buttons and timed auto-advance
// Optional macro SCENE_FRAME_SYNC_EN defers scene commits to the next frame_start pulse.
module vga_scene_seq #(
    parameter int NUM_SCENES      = 3,
    parameter int IDX_W           = 2,
    parameter int INIT_SCENE      = 0,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_PERIOD     = 250000000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  btn_next_n,
    input  logic                  btn_prev_n,
    input  logic                  auto_en,
`ifdef SCENE_FRAME_SYNC_EN
    input  logic                  frame_start,
`endif
    output logic [IDX_W-1:0]      scene_idx,
    output logic [NUM_SCENES-1:0] scene_onehot,
    output logic                  scene_change
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int AU_W = $clog2(AUTO_PERIOD);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AU_W-1:0]  AU_LAST  = AU_W'(AUTO_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SCENES - 1);
    localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(INIT_SCENE);

    // Bit 0 is the next button, bit 1 the prev button.
    logic [1:0]      r_s1, r_s2, r_db, r_db_d;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [AU_W-1:0] r_auto_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [NUM_SCENES-1:0] r_onehot;
    logic r_change;

    logic w_next_evt, w_prev_evt, w_manual, w_auto_tick, w_accept, w_commit;
    logic [IDX_W-1:0] w_base, w_target, w_commit_val;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_s1   <= 2'b11;
            r_s2   <= 2'b11;
            r_db   <= 2'b11;
            r_db_d <= 2'b11;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_s1   <= {btn_prev_n, btn_next_n};
            r_s2   <= r_s1;
            r_db_d <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_s2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_next_evt  = r_db_d[0] & ~r_db[0];
    assign w_prev_evt  = r_db_d[1] & ~r_db[1];
    assign w_manual    = w_next_evt | w_prev_evt;
    assign w_auto_tick = auto_en & ~w_manual & (r_auto_cnt == AU_LAST);
    // Simultaneous next+prev cancel each other out.
    assign w_accept    = (w_next_evt ^ w_prev_evt) | w_auto_tick;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_auto_cnt <= '0;
        end else if (!auto_en || w_manual || r_auto_cnt == AU_LAST) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end

    always_comb begin
        w_target = w_base;
        if (w_prev_evt && !w_next_evt) begin
            w_target = (w_base == '0) ? IDX_LAST : w_base - 1'b1;
        end else if (w_accept) begin
            w_target = (w_base == IDX_LAST) ? '0 : w_base + 1'b1;
        end
    end

`ifdef SCENE_FRAME_SYNC_EN
    typedef enum logic {S_IDLE, S_PENDING} state_t;
    state_t r_state, w_state_nxt;
    logic [IDX_W-1:0] r_pend;
    logic w_pend_load;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_PENDING;
            S_PENDING: if (frame_start && !w_accept) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // While pending, new events re-target relative to the pending value.
    always_comb begin
        w_pend_load  = w_accept;
        w_commit     = (r_state == S_PENDING) && frame_start;
        w_commit_val = r_pend;
        w_base       = (r_state == S_PENDING) ? r_pend : r_idx;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)          r_pend <= IDX_INIT;
        else if (w_pend_load) r_pend <= w_target;
    end
`else
    assign w_base       = r_idx;
    assign w_commit     = w_accept;
    assign w_commit_val = w_target;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_idx    <= IDX_INIT;
            r_onehot <= NUM_SCENES'(1) << IDX_INIT;
            r_change <= 1'b0;
        end else begin
            r_change <= w_commit && (w_commit_val != r_idx);
            if (w_commit) begin
                r_idx    <= w_commit_val;
                r_onehot <= NUM_SCENES'(1) << w_commit_val;
            end
        end
    end

    assign scene_idx    = r_idx;
    assign scene_onehot = r_onehot;
    assign scene_change = r_change;

endmodule

// File: tb/tb_vga_scene_seq.sv
// tb/tb_vga_scene_seq.sv - randomized and directed bench for vga_scene_seq against a window/time-based model
module tb_vga_scene_seq;

    localparam int NS  = 5;
    localparam int IW  = 3;
    localparam int DEB = 4;
    localparam int AP  = 10;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic btn_next_n = 1'b1;
    logic btn_prev_n = 1'b1;
    logic auto_en = 1'b0;
    logic [IW-1:0] scene_idx;
    logic [NS-1:0] scene_onehot;
    logic scene_change;

    vga_scene_seq #(
        .NUM_SCENES(NS), .IDX_W(IW), .INIT_SCENE(0),
        .DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(AP)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .btn_next_n(btn_next_n), .btn_prev_n(btn_prev_n), .auto_en(auto_en),
        .scene_idx(scene_idx), .scene_onehot(scene_onehot), .scene_change(scene_change)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: a button level is accepted once the last DEB synchronised samples
    // (raw samples two edges old) all disagree with it; auto ticks AP edges after the last anchor.
    int       m_idx;
    bit       m_chg;
    bit [1:0] m_db, m_fall;
    bit [7:0] h_n, h_p;
    int       e_cnt = 0;
    int       anchor = 0;

    function automatic void m_reset();
        m_idx  = 0;
        m_chg  = 1'b0;
        m_db   = 2'b11;
        m_fall = 2'b00;
        h_n    = 8'hFF;
        h_p    = 8'hFF;
        anchor = e_cnt;
    endfunction

    function automatic void m_edge(input bit nx, input bit pv, input bit au);
        bit nxt, prv, tick;
        nxt  = m_fall[0];
        prv  = m_fall[1];
        tick = 1'b0;
        if (!au || nxt || prv) anchor = e_cnt;
        else if (e_cnt - anchor == AP) begin
            tick   = 1'b1;
            anchor = e_cnt;
        end
        m_chg = 1'b0;
        if (nxt && !prv) begin
            m_idx = (m_idx + 1) % NS; m_chg = 1'b1;
        end else if (prv && !nxt) begin
            m_idx = (m_idx + NS - 1) % NS; m_chg = 1'b1;
        end else if (!nxt && !prv && tick) begin
            m_idx = (m_idx + 1) % NS; m_chg = 1'b1;
        end
        h_n = {h_n[6:0], nx};
        h_p = {h_p[6:0], pv};
        m_fall = 2'b00;
        if (h_n[5:2] == {4{~m_db[0]}}) begin m_fall[0] = m_db[0]; m_db[0] = ~m_db[0]; end
        if (h_p[5:2] == {4{~m_db[1]}}) begin m_fall[1] = m_db[1]; m_db[1] = ~m_db[1]; end
    endfunction

    function automatic logic [NS-1:0] exp_oh();
        logic [NS-1:0] one;
        one = NS'(1);
        return one << m_idx;
    endfunction

    task automatic step(input bit nx, input bit pv, input bit au);
        btn_next_n = nx;
        btn_prev_n = pv;
        auto_en    = au;
        @(posedge sys_clk);
        e_cnt++;
        if (sys_rst) m_reset();
        else         m_edge(nx, pv, au);
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step(1, 1, 0);
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step(1, 1, 0);
        step(1, 1, 0);
        n_vec++;
        if (scene_idx !== 3'd0 || scene_onehot !== 5'b00001 || scene_change !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: idx=%0d oh=%b chg=%b want idx=0 oh=00001 chg=0", scene_idx, scene_onehot, scene_change);
        end
        sys_rst = 1'b0;
        step(1, 1, 0); step(1, 1, 0);
        for (int s = 0; s < 3; s++) step(0, 1, 1);
        sys_rst = 1'b1;
        #1;
        n_vec++;
        if (scene_idx !== 3'd0 || scene_onehot !== 5'b00001 || scene_change !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: idx=%0d oh=%b chg=%b want idx=0 oh=00001 chg=0", scene_idx, scene_onehot, scene_change);
        end
        step(1, 1, 0);
        sys_rst = 1'b0;
        for (int s = 0; s < 12; s++) begin
            step(1, 1, 0);
            n_vec++;
            if (scene_idx !== IW'(m_idx) || scene_onehot !== exp_oh() || scene_change !== m_chg) begin
                n_err++;
                $display("FAIL reset_quiet s=%0d: idx=%0d chg=%b want idx=%0d chg=%b", s, scene_idx, scene_change, m_idx, m_chg);
            end
        end
    endtask

    task automatic test_debounce();
        int first_chg, n_chg;
        for (int s = 1; s <= 13; s++) begin
            step((s <= 3) ? 1'b0 : 1'b1, 1, 0);
            n_vec++;
            if (scene_idx !== IW'(m_idx) || scene_onehot !== exp_oh() || scene_change !== m_chg) begin
                n_err++;
                $display("FAIL glitch s=%0d: idx=%0d chg=%b want idx=%0d chg=%b", s, scene_idx, scene_change, m_idx, m_chg);
            end
        end
        n_vec++;
        if (scene_idx !== 3'd0) begin
            n_err++;
            $display("FAIL glitch_idx: idx=%0d want 0", scene_idx);
        end
        first_chg = -1;
        n_chg = 0;
        for (int s = 1; s <= 30; s++) begin
            step((s <= 20) ? 1'b0 : 1'b1, 1, 0);
            if (scene_change === 1'b1) begin
                n_chg++;
                if (first_chg < 0) first_chg = s;
            end
            n_vec++;
            if (scene_idx !== IW'(m_idx) || scene_onehot !== exp_oh() || scene_change !== m_chg) begin
                n_err++;
                $display("FAIL hold s=%0d: idx=%0d chg=%b want idx=%0d chg=%b", s, scene_idx, scene_change, m_idx, m_chg);
            end
        end
        n_vec++;
        if (first_chg != 7 || n_chg != 1 || scene_idx !== 3'd1) begin
            n_err++;
            $display("FAIL hold_latency: first=%0d pulses=%0d idx=%0d want first=7 pulses=1 idx=1", first_chg, n_chg, scene_idx);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int g = 0; g < 6; g++) begin
            for (int s = 0; s < 12; s++) begin
                if (g < 5) step((s < 5) ? 1'b0 : 1'b1, 1, 0);
                else       step(1, (s < 5) ? 1'b0 : 1'b1, 0);
                n_vec++;
                if (scene_idx !== IW'(m_idx) || scene_onehot !== exp_oh() || scene_change !== m_chg) begin
                    n_err++;
                    $display("FAIL wrap g=%0d s=%0d: idx=%0d chg=%b want idx=%0d chg=%b", g, s, scene_idx, scene_change, m_idx, m_chg);
                end
            end
            n_vec++;
            if (scene_idx !== IW'((g < 5) ? (g + 1) % NS : NS - 1)) begin
                n_err++;
                $display("FAIL wrap_idx g=%0d: idx=%0d want %0d", g, scene_idx, (g < 5) ? (g + 1) % NS : NS - 1);
            end
        end
    endtask

    task automatic test_simultaneous();
        int first_chg, start_idx;
        start_idx = m_idx;
        first_chg = -1;
        for (int s = 1; s <= 20; s++) begin
            step((s <= 6) ? 1'b0 : 1'b1, (s <= 6) ? 1'b0 : 1'b1, 1);
            if (scene_change === 1'b1 && first_chg < 0) first_chg = s;
            n_vec++;
            if (scene_idx !== IW'(m_idx) || scene_onehot !== exp_oh() || scene_change !== m_chg) begin
                n_err++;
                $display("FAIL simul s=%0d: idx=%0d chg=%b want idx=%0d chg=%b", s, scene_idx, scene_change, m_idx, m_chg);
            end
        end
        n_vec++;
        if (first_chg != 17 || scene_idx !== IW'((start_idx + 1) % NS)) begin
            n_err++;
            $display("FAIL simul_auto_clear: first=%0d idx=%0d want first=17 idx=%0d", first_chg, scene_idx, (start_idx + 1) % NS);
        end
        for (int s = 0; s < 6; s++) step(1, 1, 0);
    endtask

    task automatic test_auto();
        int exp_steps [6] = '{10, 20, 30, 35, 45, 55};
        int got_steps [$];
        do_reset();
        for (int g = 0; g < 2; g++)
            for (int s = 0; s < 12; s++) step((s < 5) ? 1'b0 : 1'b1, 1, 0);
        n_vec++;
        if (scene_idx !== 3'd2) begin
            n_err++;
            $display("FAIL auto_setup: idx=%0d want 2", scene_idx);
        end
        for (int s = 1; s <= 60; s++) begin
            step((s >= 29 && s <= 34) ? 1'b0 : 1'b1, 1, 1);
            if (scene_change === 1'b1) got_steps.push_back(s);
            n_vec++;
            if (scene_idx !== IW'(m_idx) || scene_onehot !== exp_oh() || scene_change !== m_chg) begin
                n_err++;
                $display("FAIL auto s=%0d: idx=%0d chg=%b want idx=%0d chg=%b", s, scene_idx, scene_change, m_idx, m_chg);
            end
        end
        n_vec++;
        if (got_steps.size() != 6) begin
            n_err++;
            $display("FAIL auto_count: pulses=%0d want 6", got_steps.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (got_steps[i] != exp_steps[i]) begin
                    n_err++;
                    $display("FAIL auto_time i=%0d: step=%0d want %0d", i, got_steps[i], exp_steps[i]);
                end
            end
        end
        n_vec++;
        if (scene_idx !== 3'd3) begin
            n_err++;
            $display("FAIL auto_final: idx=%0d want 3", scene_idx);
        end
    endtask

    task automatic test_random();
        bit nx, pv, au;
        int len;
        au = 1'b0;
        for (int seg = 0; seg < 80; seg++) begin
            nx  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            pv  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 5) == 0) au = ~au;
            len = $urandom_range(1, 9);
            for (int s = 0; s < len; s++) begin
                step(nx, pv, au);
                n_vec++;
                if (scene_idx >= NS || scene_idx !== IW'(m_idx) || scene_onehot !== exp_oh() || scene_change !== m_chg) begin
                    n_err++;
                    $display("FAIL random seg=%0d s=%0d: idx=%0d oh=%b chg=%b want idx=%0d chg=%b", seg, s, scene_idx, scene_onehot, scene_change, m_idx, m_chg);
                end
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_debounce();
        test_wrap();
        test_simultaneous();
        test_auto();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
